// File: rtl/edge_erode.sv
// Morphological erosion of a 3-bit edge-label map: a pixel survives only if it and its
// four direct neighbours are non-zero. Source is read through a 3x3 window, one read in flight.
module edge_erode #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int ADDR_W   = 19,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] edge_addr_read,
    input  logic [2:0]        bram_read,
    output logic              edge_we,
    output logic [ADDR_W-1:0] edge_addr_write,
    output logic [2:0]        bram_write
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int CW   = $clog2(READ_LAT + 1);
    localparam logic [ADDR_W-1:0] W_A = ADDR_W'(WIDTH);

    typedef enum logic [2:0] {IDLE, CLEAR, PRIME, FETCH, EVAL, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    done_q, done_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       raddr_q, raddr_d;
    logic [ADDR_W-1:0]       waddr_q, waddr_d;
    logic [2:0]              wdata_q, wdata_d;
    logic [ADDR_W-1:0]       x_q, x_d;
    logic [ADDR_W-1:0]       y_q, y_d;
    logic [ADDR_W-1:0]       row_base_q, row_base_d;
    logic [1:0]              rd_row_q, rd_row_d;
    logic [1:0]              rd_col_q, rd_col_d;
    logic [CW-1:0]           wait_q, wait_d;
    // win_q[col][row]; col 2 doubles as the load register for the incoming column
    logic [2:0][2:0][2:0]    win_q, win_d;
    logic                    capture;
    logic                    survive;

    // row_base is the start address of the centre row, so the window rows sit at -W, 0, +W
    function automatic logic [ADDR_W-1:0] rd_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] col,
                                                  input logic [1:0]        row);
        case (row)
            2'd0:    rd_addr = base - W_A + col;
            2'd1:    rd_addr = base + col;
            default: rd_addr = base + W_A + col;
        endcase
    endfunction

    assign capture = (wait_q == CW'(READ_LAT));
    assign survive = (win_q[1][1] != 3'd0) && (win_q[1][0] != 3'd0) && (win_q[1][2] != 3'd0)
                  && (win_q[0][1] != 3'd0) && (win_q[2][1] != 3'd0);

    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        we_d       = 1'b0;
        raddr_d    = raddr_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        rd_row_d   = rd_row_q;
        rd_col_d   = rd_col_q;
        wait_d     = wait_q;
        win_d      = win_q;
        if ((state_q == PRIME || state_q == FETCH) && !capture)
            wait_d = wait_q + CW'(1);
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    state_d = CLEAR;
                    we_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = 3'd0;
                end
            end
            CLEAR: begin
                if (waddr_q == ADDR_W'(NPIX - 1)) begin
                    state_d    = PRIME;
                    row_base_d = W_A;
                    y_d        = ADDR_W'(1);
                    x_d        = ADDR_W'(1);
                    rd_row_d   = 2'd0;
                    rd_col_d   = 2'd0;
                    wait_d     = '0;
                    raddr_d    = rd_addr(W_A, '0, 2'd0);
                end else begin
                    we_d    = 1'b1;
                    waddr_d = waddr_q + ADDR_W'(1);
                    wdata_d = 3'd0;
                end
            end
            PRIME: begin
                if (capture) begin
                    win_d[rd_col_q][rd_row_q] = bram_read;
                    wait_d = '0;
                    if (rd_row_q != 2'd2) begin
                        rd_row_d = rd_row_q + 2'd1;
                        raddr_d  = rd_addr(row_base_q, ADDR_W'(rd_col_q), rd_row_q + 2'd1);
                    end else if (rd_col_q == 2'd0) begin
                        rd_row_d = 2'd0;
                        rd_col_d = 2'd1;
                        raddr_d  = rd_addr(row_base_q, ADDR_W'(1), 2'd0);
                    end else begin
                        state_d  = FETCH;
                        rd_row_d = 2'd0;
                        rd_col_d = 2'd2;
                        raddr_d  = rd_addr(row_base_q, x_q + ADDR_W'(1), 2'd0);
                    end
                end
            end
            FETCH: begin
                if (capture) begin
                    win_d[2][rd_row_q] = bram_read;
                    wait_d = '0;
                    if (rd_row_q != 2'd2) begin
                        rd_row_d = rd_row_q + 2'd1;
                        raddr_d  = rd_addr(row_base_q, x_q + ADDR_W'(1), rd_row_q + 2'd1);
                    end else begin
                        // the bottom-right pixel is not part of the cross, so it can land now
                        state_d = EVAL;
                        we_d    = 1'b1;
                        waddr_d = row_base_q + x_q;
                        wdata_d = survive ? win_q[1][1] : 3'd0;
                    end
                end
            end
            EVAL: begin
                win_d[0] = win_q[1];
                win_d[1] = win_q[2];
                wait_d   = '0;
                rd_row_d = 2'd0;
                if (x_q < ADDR_W'(WIDTH - 2)) begin
                    state_d  = FETCH;
                    x_d      = x_q + ADDR_W'(1);
                    rd_col_d = 2'd2;
                    raddr_d  = rd_addr(row_base_q, x_q + ADDR_W'(2), 2'd0);
                end else if (y_q < ADDR_W'(HEIGHT - 2)) begin
                    state_d    = PRIME;
                    y_d        = y_q + ADDR_W'(1);
                    x_d        = ADDR_W'(1);
                    row_base_d = row_base_q + W_A;
                    rd_col_d   = 2'd0;
                    raddr_d    = row_base_q;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!start && state_q != IDLE && state_q != DONE) begin
            state_d = IDLE;
            we_d    = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= 3'd0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            rd_row_q   <= 2'd0;
            rd_col_q   <= 2'd0;
            wait_q     <= '0;
            win_q      <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            we_q       <= we_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            rd_row_q   <= rd_row_d;
            rd_col_q   <= rd_col_d;
            wait_q     <= wait_d;
            win_q      <= win_d;
        end
    end

    assign done            = done_q;
    assign edge_we         = we_q;
    assign edge_addr_read  = raddr_q;
    assign edge_addr_write = waddr_q;
    assign bram_write      = wdata_q;

endmodule

// File: tb/tb_edge_erode.sv
// Directed bench for edge_erode on a 16x12 frame: one instance with READ_LAT=2, one with READ_LAT=1.
module tb_edge_erode;
    localparam int W = 16;
    localparam int H = 12;
    localparam int AW = 8;
    localparam int NPIX = W * H;
    localparam int LAT2 = NPIX + (H - 2) * (6 + 3 * (W - 2)) * 3 + (H - 2) * (W - 2);
    localparam int LAT1 = NPIX + (H - 2) * (6 + 3 * (W - 2)) * 2 + (H - 2) * (W - 2);
    localparam int NWR = NPIX + (H - 2) * (W - 2);

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;
    logic done_a, done_b;
    logic [AW-1:0] raddr_a, raddr_b, waddr_a, waddr_b;
    logic [2:0] rdata_a, rdata_b, wdata_a, wdata_b;
    logic we_a, we_b;

    logic [2:0] src [0:255];
    logic [2:0] dst [0:255];
    logic [2:0] pa1, pa2, pb1;
    int wcnt, nzw, oob;
    logic clr_req;
    int total, bad;

    always #5 clk = ~clk;

    edge_erode #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .READ_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .done(done_a),
        .edge_addr_read(raddr_a), .bram_read(rdata_a), .edge_we(we_a),
        .edge_addr_write(waddr_a), .bram_write(wdata_a));

    edge_erode #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .READ_LAT(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .done(done_b),
        .edge_addr_read(raddr_b), .bram_read(rdata_b), .edge_we(we_b),
        .edge_addr_write(waddr_b), .bram_write(wdata_b));

    assign rdata_a = pa2;
    assign rdata_b = pb1;

    // Source BRAM models (registered read plus optional extra stage) and destination capture
    always @(posedge clk) begin
        pa1 <= src[raddr_a];
        pa2 <= pa1;
        pb1 <= src[raddr_b];
        if (clr_req) begin
            for (int i = 0; i < 256; i++) dst[i] <= 3'd7;
            wcnt <= 0;
            nzw  <= 0;
            oob  <= 0;
        end else if (we_a || we_b) begin
            if (we_a) begin
                dst[waddr_a] <= wdata_a;
                if (int'(waddr_a) >= NPIX) oob <= oob + 1;
                if (wdata_a != 3'd0) nzw <= nzw + 1;
            end else begin
                dst[waddr_b] <= wdata_b;
                if (int'(waddr_b) >= NPIX) oob <= oob + 1;
                if (wdata_b != 3'd0) nzw <= nzw + 1;
            end
            wcnt <= wcnt + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // 0 zero, 1 5x5 block of 2, 2 horizontal line of 3 on row 4, 3 full frame of 1
    task automatic load_src(input int pat);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                case (pat)
                    1: src[y*W+x] = (x >= 5 && x <= 9 && y >= 5 && y <= 9) ? 3'd2 : 3'd0;
                    2: src[y*W+x] = (y == 4) ? 3'd3 : 3'd0;
                    3: src[y*W+x] = 3'd1;
                    default: src[y*W+x] = 3'd0;
                endcase
            end
    endtask

    function automatic int exp_pix(input int pat, input int x, input int y);
        case (pat)
            1: return (x >= 6 && x <= 8 && y >= 6 && y <= 8) ? 2 : 0;
            3: return (x >= 1 && x <= 14 && y >= 1 && y <= 10) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic clear_dst();
        @(negedge clk) clr_req = 1'b1;
        @(negedge clk) clr_req = 1'b0;
    endtask

    task automatic verify_img(input string tag, input int pat);
        int nbad;
        nbad = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (int'(dst[y*W+x]) != exp_pix(pat, x, y)) nbad++;
        chk({tag, "_image"}, nbad, 0);
        chk({tag, "_oob"}, oob, 0);
    endtask

    task automatic wait_writes(input int n);
        int k;
        k = 0;
        while (wcnt < n && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        if (wcnt < n) chk("wait_writes_timeout", wcnt, n);
    endtask

    task automatic run_frame(input string tag, input int which, input int pat, input int lat);
        int cyc;
        logic d;
        clear_dst();
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        cyc = 0;
        d = 1'b0;
        while (!d && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            d = (which == 0) ? done_a : done_b;
        end
        chk({tag, "_latency"}, cyc, lat + 1);
        chk({tag, "_writes"}, wcnt, NWR);
        repeat (3) @(posedge clk);
        #1 chk({tag, "_done_hold"}, int'((which == 0) ? done_a : done_b), 1);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_done_clear"}, int'((which == 0) ? done_a : done_b), 0);
        verify_img(tag, pat);
        $display("%s: cycles=%0d writes=%0d nonzero_writes=%0d", tag, cyc, wcnt, nzw);
    endtask

    initial begin
        int snap;
        total = 0;
        bad = 0;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        clr_req = 1'b0;
        load_src(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", int'(we_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_raddr", int'(raddr_a), 0);
        chk("rst_waddr", int'(waddr_a), 0);
        chk("rst_wdata", int'(wdata_a), 0);
        @(negedge clk) rst = 1'b0;
        $display("reset: we=%0d done=%0d", we_a, done_a);

        // 1: all-zero source
        run_frame("t1_zero", 0, 0, LAT2);
        chk("t1_nonzero_writes", nzw, 0);

        // 2: 5x5 block
        load_src(1);
        run_frame("t2_block", 0, 1, LAT2);
        chk("t2_centre", int'(dst[7*W+7]), 2);
        chk("t2_corner_eroded", int'(dst[5*W+5]), 0);
        chk("t2_edge_eroded", int'(dst[9*W+7]), 0);

        // 3: one-pixel horizontal line
        load_src(2);
        run_frame("t3_line", 0, 2, LAT2);
        chk("t3_nonzero_writes", nzw, 0);

        // 4: full frame
        load_src(3);
        run_frame("t4_full", 0, 3, LAT2);
        chk("t4_border", int'(dst[0]), 0);
        chk("t4_inner_corner", int'(dst[1*W+1]), 1);

        // 5: abort after 50 interior writes, then restart with the block
        load_src(1);
        clear_dst();
        start_a = 1'b1;
        wait_writes(NPIX + 50);
        start_a = 1'b0;
        @(posedge clk); #1;
        chk("t5_abort_we", int'(we_a), 0);
        chk("t5_abort_done", int'(done_a), 0);
        snap = wcnt;
        repeat (20) @(posedge clk);
        #1 chk("t5_no_writes", wcnt, snap);
        $display("t5_abort: writes_at_abort=%0d", snap);
        run_frame("t5_restart", 0, 1, LAT2);

        // 6: async reset mid-FETCH, then rerun on the READ_LAT=1 instance
        clear_dst();
        start_a = 1'b1;
        wait_writes(NPIX + 5);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_we", int'(we_a), 0);
        chk("t6_rst_done", int'(done_a), 0);
        chk("t6_rst_raddr", int'(raddr_a), 0);
        chk("t6_rst_waddr", int'(waddr_a), 0);
        chk("t6_rst_wdata", int'(wdata_a), 0);
        start_a = 1'b0;
        snap = wcnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1 chk("t6_no_writes", wcnt, snap);
        $display("t6_reset: writes_before_reset=%0d", snap);
        run_frame("t6_lat1", 1, 1, LAT1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
